// File: rtl/pia_arb_pkg.sv
// pia_arb_pkg: shared types and constants for the PIA bus arbiter.
// Holds the access sequencer state type, the requester ids and the
// register map of the PIA.
package pia_arb_pkg;

    // Access sequencer: pick a winner, strobe the PIA, capture its data.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    // Requester ids as stored in the winner register.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // PIA register map.
    localparam logic [6:0] SWCHA  = 7'h00;
    localparam logic [6:0] SWACNT = 7'h01;
    localparam logic [6:0] SWCHB  = 7'h02;
    localparam logic [6:0] SWBCNT = 7'h03;
    localparam logic [6:0] INTIM  = 7'h04;
    localparam logic [6:0] INSTAT = 7'h05;
    localparam logic [6:0] TIM1T  = 7'h14;
    localparam logic [6:0] TIM8T  = 7'h15;
    localparam logic [6:0] TIM64T = 7'h16;
    localparam logic [6:0] T1024T = 7'h17;

endpackage

// File: rtl/pia_bus_arbiter_tick.sv
// pia_tick_gen: divides the system clock by CLK_DIV to produce the
// one-cycle PIA timer enable. Free running; nothing can stall it.
module pia_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pia_enable_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] count;

    // Count 0..CLK_DIV-1; the enable is set one count early so the registered pulse lines up with the last count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count        <= '0;
            pia_enable_o <= 1'b0;
        end else begin
            count        <= (count == LAST) ? '0 : count + 1'b1;
            pia_enable_o <= (count == PRE);
        end
    end

endmodule

// File: rtl/pia_bus_arbiter.sv
// pia_bus_arbiter: shares the PIA register bus between the CPU bus
// interface and the debug/host port, serialising every access into a
// single-cycle PIA strobe and returning read data with an ack pulse.
// Build option PIA_ARB_DBG_WRITE_EN: when defined, debug writes reach the
// PIA; otherwise they complete and ack but the PIA strobe is suppressed.
module pia_bus_arbiter
    import pia_arb_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DBG_WAIT_MAX = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cpu_stb_i,
    input  logic       cpu_we_i,
    input  logic [6:0] cpu_adr_i,
    input  logic [7:0] cpu_dat_i,
    output logic       cpu_ack_o,
    output logic [7:0] cpu_dat_o,
    input  logic       dbg_stb_i,
    input  logic       dbg_we_i,
    input  logic [6:0] dbg_adr_i,
    input  logic [7:0] dbg_dat_i,
    output logic       dbg_ack_o,
    output logic [7:0] dbg_dat_o,
    output logic       pia_enable_o,
    output logic       pia_stb_o,
    output logic       pia_we_o,
    output logic [6:0] pia_adr_o,
    output logic [7:0] pia_dat_o,
    input  logic [7:0] pia_dat_i
);

`ifdef PIA_ARB_DBG_WRITE_EN
    localparam logic DBG_WRITE_EN = 1'b1;
`else
    localparam logic DBG_WRITE_EN = 1'b0;
`endif

    localparam logic [7:0] WAIT_MAX = 8'(DBG_WAIT_MAX);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       winner;
    logic [7:0] starv_cnt;
    logic       starved;
    logic       cpu_req;
    logic       dbg_req;
    logic       cpu_win;
    logic       dbg_win;
    logic       issue_allowed;

    pia_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pia_enable_o (pia_enable_o)
    );

    // A requester acked this cycle is still showing its old stb, so it is masked.
    // A masked CPU still holds priority: debug only overtakes it when starved
    // or when the CPU has dropped its strobe, otherwise the slot stays empty.
    assign cpu_req = cpu_stb_i & ~cpu_ack_o;
    assign dbg_req = dbg_stb_i & ~dbg_ack_o;
    assign starved = (starv_cnt == WAIT_MAX);
    assign dbg_win = (state == IDLE) & dbg_req & (starved | ~cpu_stb_i);
    assign cpu_win = (state == IDLE) & cpu_req & ~dbg_win;

    // Debug writes are swallowed here unless the build forwards them.
    assign issue_allowed = DBG_WRITE_EN | ~((winner == REQ_DBG) & pia_we_o);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a grant starts the fixed three-cycle access.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_win || dbg_win) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: the PIA strobe exists only in ISSUE.
    always_comb begin
        pia_stb_o = (state == ISSUE) && issue_allowed;
    end

    // Latch the winner and its command; these hold between accesses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            winner    <= REQ_CPU;
            pia_we_o  <= 1'b0;
            pia_adr_o <= 7'h00;
            pia_dat_o <= 8'h00;
        end else if (cpu_win) begin
            winner    <= REQ_CPU;
            pia_we_o  <= cpu_we_i;
            pia_adr_o <= cpu_adr_i;
            pia_dat_o <= cpu_dat_i;
        end else if (dbg_win) begin
            winner    <= REQ_DBG;
            pia_we_o  <= dbg_we_i;
            pia_adr_o <= dbg_adr_i;
            pia_dat_o <= dbg_dat_i;
        end
    end

    // Count CPU grants taken while debug waits; debug is forced through at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starv_cnt <= 8'd0;
        end else if (state == IDLE) begin
            if (dbg_win || !dbg_stb_i) begin
                starv_cnt <= 8'd0;
            end else if (cpu_win && dbg_req && !starved) begin
                starv_cnt <= starv_cnt + 8'd1;
            end
        end
    end

    // Return read data and pulse the winner's ack as the access leaves CAPTURE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_ack_o <= 1'b0;
            dbg_ack_o <= 1'b0;
            cpu_dat_o <= 8'h00;
            dbg_dat_o <= 8'h00;
        end else begin
            cpu_ack_o <= (state == CAPTURE) && (winner == REQ_CPU);
            dbg_ack_o <= (state == CAPTURE) && (winner == REQ_DBG);
            if ((state == CAPTURE) && !pia_we_o) begin
                if (winner == REQ_CPU) begin
                    cpu_dat_o <= pia_dat_i;
                end else begin
                    dbg_dat_o <= pia_dat_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_pia_bus_arbiter.sv
// tb_pia_bus_arbiter: self-checking bench for pia_bus_arbiter.
// A timeline model (grant cycle + fixed offsets) predicts every output on
// every cycle; directed table vectors and sequences sit on top of it.
module tb_pia_bus_arbiter;
    import pia_arb_pkg::*;

    localparam int CLK_DIV      = 4;
    localparam int DBG_WAIT_MAX = 8;
`ifdef PIA_ARB_DBG_WRITE_EN
    localparam bit DBG_WR_EN = 1'b1;
`else
    localparam bit DBG_WR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cpu_stb_i, cpu_we_i, dbg_stb_i, dbg_we_i;
    logic [6:0] cpu_adr_i, dbg_adr_i;
    logic [7:0] cpu_dat_i, dbg_dat_i;
    logic       cpu_ack_o, dbg_ack_o, pia_enable_o, pia_stb_o, pia_we_o;
    logic [7:0] cpu_dat_o, dbg_dat_o, pia_dat_o;
    logic [6:0] pia_adr_o;
    logic [7:0] pia_dat_i = 8'h00;

    always #5 clk = ~clk;

    pia_bus_arbiter #(
        .CLK_DIV      (CLK_DIV),
        .DBG_WAIT_MAX (DBG_WAIT_MAX)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cpu_stb_i    (cpu_stb_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_adr_i    (cpu_adr_i),
        .cpu_dat_i    (cpu_dat_i),
        .cpu_ack_o    (cpu_ack_o),
        .cpu_dat_o    (cpu_dat_o),
        .dbg_stb_i    (dbg_stb_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_adr_i    (dbg_adr_i),
        .dbg_dat_i    (dbg_dat_i),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_dat_o    (dbg_dat_o),
        .pia_enable_o (pia_enable_o),
        .pia_stb_o    (pia_stb_o),
        .pia_we_o     (pia_we_o),
        .pia_adr_o    (pia_adr_o),
        .pia_dat_o    (pia_dat_o),
        .pia_dat_i    (pia_dat_i)
    );

    // Power-up contents of the PIA register file as seen by the bench.
    function automatic logic [7:0] pia_init(input logic [6:0] adr);
        return (adr == INTIM) ? 8'h5A : ({1'b0, adr} ^ 8'hC3);
    endfunction

    // Behavioural PIA: writes land on the strobe, reads are registered.
    logic [7:0]   pia_mem [0:127];
    logic [127:0] pia_written = '0;
    always @(posedge clk) begin
        if (pia_stb_o) begin
            if (pia_we_o) begin
                pia_mem[pia_adr_o]     <= pia_dat_o;
                pia_written[pia_adr_o] <= 1'b1;
            end else begin
                pia_dat_i <= pia_written[pia_adr_o] ? pia_mem[pia_adr_o] : pia_init(pia_adr_o);
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int stb_seen = 0;
    int en_seen = 0;

    // Reference model state: one access at a time, located by its grant cycle.
    int         m_cyc, m_since, m_g, m_starv;
    bit         m_active, m_port, m_we, m_pwe;
    logic [6:0] m_adr, m_padr;
    logic [7:0] m_dat, m_rd, m_pdat, m_cpu_dat, m_dbg_dat;
    logic [7:0] m_mem [0:127];

    function automatic bit exp_stb();
        return m_active && (m_cyc == m_g + 1) && (DBG_WR_EN || !(m_port && m_we));
    endfunction

    function automatic bit exp_ack(input bit port);
        return m_active && (m_cyc == m_g + 3) && (m_port == port);
    endfunction

    function automatic bit exp_en();
        return (m_since % CLK_DIV) == (CLK_DIV - 1);
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_since   = 0;
        m_starv   = 0;
        m_cpu_dat = 8'h00;
        m_dbg_dat = 8'h00;
        m_pwe     = 1'b0;
        m_padr    = 7'h00;
        m_pdat    = 8'h00;
    endtask

    task automatic model_grant(input bit port, input bit we, input logic [6:0] adr, input logic [7:0] dat);
        m_active = 1'b1;
        m_g      = m_cyc;
        m_port   = port;
        m_we     = we;
        m_adr    = adr;
        m_dat    = dat;
        m_pwe    = we;
        m_padr   = adr;
        m_pdat   = dat;
    endtask

    // Advance the model across one clock edge using the inputs present now.
    task automatic model_step();
        bit a_cpu, a_dbg, cq, dq, dw, cw;
        a_cpu = exp_ack(1'b0);
        a_dbg = exp_ack(1'b1);
        if (exp_stb()) begin
            if (m_we) m_mem[m_adr] = m_dat;
            else      m_rd = m_mem[m_adr];
        end
        if (m_active && (m_cyc == m_g + 2) && !m_we) begin
            if (m_port) m_dbg_dat = m_rd;
            else        m_cpu_dat = m_rd;
        end
        if (!m_active || (m_cyc >= m_g + 3)) begin
            cq = cpu_stb_i && !a_cpu;
            dq = dbg_stb_i && !a_dbg;
            dw = dq && ((m_starv == DBG_WAIT_MAX) || !cpu_stb_i);
            cw = cq && !dw;
            if (dw) begin
                model_grant(1'b1, dbg_we_i, dbg_adr_i, dbg_dat_i);
                m_starv = 0;
            end else if (cw) begin
                model_grant(1'b0, cpu_we_i, cpu_adr_i, cpu_dat_i);
                if (dq && (m_starv < DBG_WAIT_MAX)) m_starv++;
            end
            if (!dbg_stb_i) m_starv = 0;
        end
        if (rst_i) model_reset();
        else       m_since++;
        m_cyc++;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic checkOutput();
        cmp("pia_enable", pia_enable_o, exp_en());
        cmp("pia_stb",    pia_stb_o,    exp_stb());
        cmp("cpu_ack",    cpu_ack_o,    exp_ack(1'b0));
        cmp("dbg_ack",    dbg_ack_o,    exp_ack(1'b1));
        cmp("cpu_dat",    cpu_dat_o,    m_cpu_dat);
        cmp("dbg_dat",    dbg_dat_o,    m_dbg_dat);
        cmp("pia_we",     pia_we_o,     m_pwe);
        cmp("pia_adr",    pia_adr_o,    m_padr);
        cmp("pia_dat",    pia_dat_o,    m_pdat);
    endtask

    // One clock: check mid-cycle, advance the model, land just after the next edge.
    task automatic tick();
        @(negedge clk);
        checkOutput();
        if (pia_stb_o)    stb_seen++;
        if (pia_enable_o) en_seen++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit port, input bit stb, input bit we,
                                 input logic [6:0] adr, input logic [7:0] dat);
        if (port) begin
            dbg_stb_i = stb; dbg_we_i = we; dbg_adr_i = adr; dbg_dat_i = dat;
        end else begin
            cpu_stb_i = stb; cpu_we_i = we; cpu_adr_i = adr; cpu_dat_i = dat;
        end
    endtask

    // Full handshake: hold stb until ack (bounded), then release it.
    task automatic do_access(input bit port, input bit we, input logic [6:0] adr, input logic [7:0] dat,
                             output int lat, output int strobes, output logic [7:0] rdata);
        int s0;
        s0  = stb_seen;
        lat = -1;
        applyStimulus(port, 1'b1, we, adr, dat);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (port ? dbg_ack_o : cpu_ack_o) begin
                lat = i;
                break;
            end
        end
        rdata = port ? dbg_dat_o : cpu_dat_o;
        applyStimulus(port, 1'b0, we, adr, dat);
        tick();
        strobes = stb_seen - s0;
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [6:0] adr;
        logic [7:0] dat;
        logic [7:0] exp_rd;
        int         exp_strobes;
    } vec_t;

    vec_t tbl [8];
    bit   order [$];

    initial begin
        int lat, strobes, e0, acks;
        logic [7:0] rd;
        bit cpu_busy, dbg_busy;

        // Directed accesses; exp_rd on writes is the value dat_o must keep holding.
        tbl[0] = '{REQ_CPU, 1'b0, INTIM,  8'h00, 8'h5A, 1};
        tbl[1] = '{REQ_CPU, 1'b1, TIM64T, 8'h10, 8'h5A, 1};
        tbl[2] = '{REQ_CPU, 1'b0, TIM64T, 8'h00, 8'h10, 1};
        tbl[3] = '{REQ_DBG, 1'b0, INSTAT, 8'h00, 8'hC6, 1};
        tbl[4] = '{REQ_DBG, 1'b1, SWACNT, 8'h33, 8'hC6, DBG_WR_EN ? 1 : 0};
        tbl[5] = '{REQ_DBG, 1'b0, SWACNT, 8'h00, DBG_WR_EN ? 8'h33 : 8'hC2, 1};
        tbl[6] = '{REQ_CPU, 1'b0, SWCHA,  8'h00, 8'hC3, 1};
        tbl[7] = '{REQ_DBG, 1'b0, TIM64T, 8'h00, 8'h10, 1};

        for (int a = 0; a < 128; a++) m_mem[a] = pia_init(7'(a));

        rst_i = 1'b1;
        applyStimulus(REQ_CPU, 1'b0, 1'b0, 7'h00, 8'h00);
        applyStimulus(REQ_DBG, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        m_cyc = 0;
        rst_i = 1'b0;

        // Idle after reset: enable on cycles 3, 7, 11, 15, 19 only.
        $display("[TB] idle tick check");
        e0 = en_seen;
        repeat (20) tick();
        cmp("idle_enable_pulses", en_seen - e0, 5);
        cmp("idle_no_strobe", stb_seen, 0);

        $display("[TB] table vectors");
        for (int v = 0; v < 8; v++) begin
            do_access(tbl[v].port, tbl[v].we, tbl[v].adr, tbl[v].dat, lat, strobes, rd);
            cmp($sformatf("vec%0d_latency", v), lat, 3);
            cmp($sformatf("vec%0d_strobes", v), strobes, tbl[v].exp_strobes);
            cmp($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
        end

        // Reset landing in the ISSUE cycle abandons the access.
        $display("[TB] reset during issue");
        applyStimulus(REQ_CPU, 1'b1, 1'b0, INTIM, 8'h00);
        tick();
        rst_i = 1'b1;
        applyStimulus(REQ_CPU, 1'b0, 1'b0, INTIM, 8'h00);
        tick();
        rst_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack_o) acks++;
        end
        cmp("rst_issue_no_ack", acks, 0);
        cmp("rst_issue_dat_cleared", cpu_dat_o, 8'h00);
        do_access(REQ_CPU, 1'b0, SWCHA, 8'h00, lat, strobes, rd);
        cmp("post_rst_latency", lat, 3);
        cmp("post_rst_rdata", rd, 8'hC3);

        // Both ports hammering: eight CPU grants before debug is forced in.
        $display("[TB] continuous contention");
        applyStimulus(REQ_CPU, 1'b1, 1'b0, 7'($urandom_range(0, 127)), 8'h00);
        applyStimulus(REQ_DBG, 1'b1, 1'b0, 7'($urandom_range(0, 127)), 8'h00);
        for (int c = 0; c < 200 && order.size() < 20; c++) begin
            tick();
            if (cpu_ack_o) begin
                order.push_back(REQ_CPU);
                applyStimulus(REQ_CPU, 1'b1, 1'b0, 7'($urandom_range(0, 127)), 8'h00);
            end
            if (dbg_ack_o) begin
                order.push_back(REQ_DBG);
                applyStimulus(REQ_DBG, 1'b1, 1'b0, 7'($urandom_range(0, 127)), 8'h00);
            end
        end
        cmp("cont_enough_grants", order.size() >= 9, 1);
        for (int i = 0; i < 8; i++) cmp($sformatf("cont_grant%0d_cpu", i), order[i], REQ_CPU);
        cmp("cont_grant8_dbg", order[8], REQ_DBG);
        applyStimulus(REQ_CPU, 1'b0, 1'b0, 7'h00, 8'h00);
        applyStimulus(REQ_DBG, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (6) tick();

        // Random traffic with a mid-run reset; the model checks every cycle.
        $display("[TB] random traffic");
        cpu_busy = 1'b0;
        dbg_busy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst_i = 1'b1;
                applyStimulus(REQ_CPU, 1'b0, 1'b0, 7'h00, 8'h00);
                applyStimulus(REQ_DBG, 1'b0, 1'b0, 7'h00, 8'h00);
                cpu_busy = 1'b0;
                dbg_busy = 1'b0;
            end
            if (c == 202) rst_i = 1'b0;
            if (!rst_i) begin
                if (!cpu_busy && ($urandom_range(0, 2) == 0)) begin
                    applyStimulus(REQ_CPU, 1'b1, 1'($urandom_range(0, 1)),
                                  7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
                    cpu_busy = 1'b1;
                end
                if (!dbg_busy && ($urandom_range(0, 2) == 0)) begin
                    applyStimulus(REQ_DBG, 1'b1, 1'($urandom_range(0, 1)),
                                  7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
                    dbg_busy = 1'b1;
                end
            end
            tick();
            if (cpu_busy && cpu_ack_o) begin
                applyStimulus(REQ_CPU, 1'b0, 1'b0, 7'h00, 8'h00);
                cpu_busy = 1'b0;
            end
            if (dbg_busy && dbg_ack_o) begin
                applyStimulus(REQ_DBG, 1'b0, 1'b0, 7'h00, 8'h00);
                dbg_busy = 1'b0;
            end
        end
        applyStimulus(REQ_CPU, 1'b0, 1'b0, 7'h00, 8'h00);
        applyStimulus(REQ_DBG, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so a wedged run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pia_bus_arbiter.md
Name: pia_bus_arbiter

Overview:
- Shares the single PIA register bus (stb/we/7-bit adr/8-bit data) between the 6507 CPU bus interface and a debug/host port.
- Generates the PIA timer enable tick from the system clock.
- Sits between the CPU address decoder, the debug UART bridge and the pia instance.
- Every access is serialized into a single-cycle PIA strobe. The registered PIA read data is returned to the winning requester with an ack pulse.

Parameters:
- CLK_DIV, 4: system clocks per CPU cycle; period of pia_enable_o; legal range 2..256.
- DBG_WAIT_MAX, 8: consecutive CPU grants tolerated while debug is pending before debug is forced to win; range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- cpu_stb_i  in  1  CPU request, level, held until cpu_ack_o
- cpu_we_i  in  1  CPU write when 1
- cpu_adr_i  in  7  CPU PIA register address
- cpu_dat_i  in  8  CPU write data
- cpu_ack_o  out  1  one-cycle completion pulse
- cpu_dat_o  out  8  CPU read data, valid with cpu_ack_o
- dbg_stb_i, dbg_we_i, dbg_adr_i[6:0], dbg_dat_i[7:0], dbg_ack_o, dbg_dat_o[7:0]: debug port, identical semantics to the CPU port
- pia_enable_o  out  1  timer tick to pia enable_i
- pia_stb_o  out  1  single-cycle strobe to pia
- pia_we_o  out  1  write qualifier to pia
- pia_adr_o  out  7  address to pia
- pia_dat_o  out  8  write data to pia
- pia_dat_i  in  8  pia registered read data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, tick counter 0, starvation counter 0. Reset mid-access abandons the access; no ack is issued.
- Tick:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - pia_enable_o is registered, high for one cycle when the counter equals CLK_DIV-1.
  - The tick is independent of arbitration and never stalls.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE:
  - Arbitrate among requesters whose stb is high, masking any requester whose ack_o is high in the same cycle. This prevents a double issue.
  - If no request is pending, stay in IDLE.
  - Winner latches we/adr/dat into the pia_* registers; go to ISSUE.
- Priority:
  - CPU wins by default.
  - Debug wins when the starvation counter equals DBG_WAIT_MAX, or when the CPU is not requesting.
- Starvation counter:
  - Increments, saturating at DBG_WAIT_MAX, on each CPU grant while unmasked dbg_stb_i is high.
  - Clears on a debug grant, or on any IDLE cycle with dbg_stb_i low.
- ISSUE: pia_stb_o = 1 for exactly this cycle; go to CAPTURE.
- CAPTURE:
  - On reads, latch pia_dat_i into the winner's dat_o.
  - On writes, dat_o is unchanged.
  - Go to IDLE and assert the winner's ack_o in the next cycle.
- Latency:
  - Request sampled in IDLE at cycle N: pia_stb_o at N+1, capture at N+2, ack_o and data at N+3.
  - The next grant is possible at N+3, for the other requester only.
  - Throughput is one access per 3 cycles.
- Hold rules:
  - pia_we_o, pia_adr_o and pia_dat_o hold their last values outside ISSUE.
  - dat_o holds its value until the next read completion for that port.
- Request withdrawal: a requester dropping stb before ack is illegal. The access still completes and ack still pulses.

Optional Feature:
- PIA_ARB_DBG_WRITE_EN defined: debug writes are forwarded to the PIA normally.
- Undefined:
  - Debug writes run the full FSM sequence and are acked, but pia_stb_o stays 0 during ISSUE. The PIA sees no access.
  - Debug reads are unaffected.

Decomposition:
- Package pia_arb_pkg:
  - FSM state enum (IDLE, ISSUE, CAPTURE).
  - Requester id constants (REQ_CPU=0, REQ_DBG=1).
  - PIA register address localparams: SWCHA 7'h00, SWACNT 7'h01, SWCHB 7'h02, SWBCNT 7'h03, INTIM 7'h04, INSTAT 7'h05, TIM1T 7'h14, TIM8T 7'h15, TIM64T 7'h16, T1024T 7'h17.
- Sub-module pia_tick_gen: CLK_DIV divider producing pia_enable_o.

Test Plan:
- Reset then idle 20 cycles -> pia_enable_o pulses every 4th cycle (cycles 3, 7, 11, ...); all acks and pia_stb_o 0.
- CPU read adr 7'h04 with pia_dat_i=8'h5A at capture -> pia_stb_o at N+1, cpu_ack_o at N+3, cpu_dat_o=8'h5A; exactly one strobe.
- CPU write TIM64T (adr 7'h16, dat 8'h10) with stb held until ack -> one pia_stb_o, pia_we_o=1, pia_adr_o=7'h16, pia_dat_o=8'h10; no second strobe.
- CPU and debug both requesting continuously -> 8 CPU grants, then 1 debug grant, repeating; starvation counter clears after each debug grant.
- rst_i asserted in the ISSUE cycle -> no ack; the next access after reset completes normally.
- Debug write adr 7'h01, macro undefined -> dbg_ack_o at N+3 with pia_stb_o never high. With the macro defined, the strobe occurs.
